// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipe_array_arb pipeline array.
//   NUM_CH_DEF, WIDTH_DEF, DEPTH_DEF, SHARED_STAGE_DEF, SHARED_ADD_DEF:
//      default values for the top-level parameters.
//   stage_t: one pipeline stage entry (valid flag + data word).
package pipe_pkg;

   localparam int NUM_CH_DEF       = 2;
   localparam int WIDTH_DEF        = 32;
   localparam int DEPTH_DEF        = 4;
   localparam int SHARED_STAGE_DEF = 2;
   localparam logic [WIDTH_DEF-1:0] SHARED_ADD_DEF = 32'h100;

   typedef struct packed {
      logic                 valid;
      logic [WIDTH_DEF-1:0] data;
   } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for the shared arithmetic unit.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset (pointer -> 0)
//   req    in   NUM_CH request vector
//   gate   in   NUM_CH mask; a gated channel is never granted (flush)
//   grant  out  NUM_CH one-hot grant (all zero when nothing requests)
// Priority starts at the pointer; after a grant the pointer moves to
// grantee+1, otherwise it holds.
module rr_arbiter
   import pipe_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] req,
   input  logic [NUM_CH-1:0] gate,
   output logic [NUM_CH-1:0] grant
);

   localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] eff;
   logic [PW-1:0]     ptr;
   logic [PW-1:0]     ptr_nxt;
   logic [PW-1:0]     k;
   logic              found;

   always_comb begin
      eff     = req & ~gate;
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      k       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         k = PW'((int'(ptr) + i) % NUM_CH);
         if (!found && eff[k]) begin
            grant[k] = 1'b1;
            found    = 1'b1;
            ptr_nxt  = PW'((int'(k) + 1) % NUM_CH);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else begin
         ptr <= ptr_nxt;
      end
   end

endmodule

// File: rtl/pipe_array_arb.sv
// pipe_array_arb: NUM_CH independent DEPTH-stage pipelines sharing one adder
// at stage SHARED_STAGE. A round-robin arbiter picks one channel per cycle
// for the shared unit; losers see stall and hold their front stages.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   in_data    in   NUM_CH*WIDTH, channel c at [c*WIDTH +: WIDTH]
//   in_valid   in   NUM_CH input valid
//   flush      in   NUM_CH per-channel flush (clears valids at next edge)
//   out_data   out  NUM_CH*WIDTH result from the last stage
//   out_valid  out  NUM_CH one-cycle pulse per completed item
//   stall      out  NUM_CH combinational; input not accepted this cycle
// Build option: PIPE_GLOBAL_STALL_EN -- when any channel loses arbitration,
// every channel except the grantee stalls.
module pipe_array_arb
   import pipe_pkg::*;
#(
   parameter int              NUM_CH       = NUM_CH_DEF,
   parameter int              WIDTH        = WIDTH_DEF,
   parameter int              DEPTH        = DEPTH_DEF,
   parameter int              SHARED_STAGE = SHARED_STAGE_DEF,
   parameter logic [WIDTH-1:0] SHARED_ADD  = WIDTH'(SHARED_ADD_DEF)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       flush,
   output logic [NUM_CH*WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]       out_valid,
   output logic [NUM_CH-1:0]       stall
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] lose;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .gate  (flush),
      .grant (grant)
   );

   // Stall only looks at registered valids, flush and the arbiter pointer,
   // so it never depends on in_valid.
   always_comb begin
      lose = req & ~grant;
`ifdef PIPE_GLOBAL_STALL_EN
      stall = (|lose) ? ~grant : '0;
`else
      stall = lose;
`endif
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DEPTH-1:0] v;
      logic [WIDTH-1:0] d [DEPTH];

      assign req[c] = v[SHARED_STAGE-1] & ~flush[c];

      // Stalled channel: stages below SHARED_STAGE hold, SHARED_STAGE
      // takes a bubble, stages above keep draining so nothing repeats.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            v <= '0;
            for (int s = 0; s < DEPTH; s++) begin
               d[s] <= '0;
            end
         end else if (flush[c]) begin
            v <= '0;
         end else begin
            if (!stall[c]) begin
               v[0] <= in_valid[c];
               if (in_valid[c]) begin
                  d[0] <= in_data[c*WIDTH +: WIDTH];
               end
            end
            for (int s = 1; s < DEPTH; s++) begin
               if (s < SHARED_STAGE) begin
                  if (!stall[c]) begin
                     v[s] <= v[s-1];
                     if (v[s-1]) begin
                        d[s] <= d[s-1] + ONE;
                     end
                  end
               end else if (s == SHARED_STAGE) begin
                  v[s] <= v[s-1] & ~stall[c];
                  if (v[s-1] && !stall[c]) begin
                     d[s] <= d[s-1] + SHARED_ADD;
                  end
               end else begin
                  v[s] <= v[s-1];
                  if (v[s-1]) begin
                     d[s] <= d[s-1] + ONE;
                  end
               end
            end
         end
      end

      assign out_valid[c]                 = v[DEPTH-1];
      assign out_data[c*WIDTH +: WIDTH]   = d[DEPTH-1];
   end

endmodule

// File: tb/tb_pipe_array_arb.sv
// Bench for pipe_array_arb: single-item vector table, contention, streams,
// flush and mid-stream reset. Expected outputs come from a scoreboard queue.
module tb_pipe_array_arb;

`ifdef PIPE_GLOBAL_STALL_EN
   localparam int NCH = 3;
`else
   localparam int NCH = 2;
`endif
   localparam logic [31:0] TOTAL_ADD = 32'h102;

   logic              clk;
   logic              rst_n;
   logic [NCH*32-1:0] in_data;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    flush;
   logic [NCH*32-1:0] out_data;
   logic [NCH-1:0]    out_valid;
   logic [NCH-1:0]    stall;

   pipe_array_arb #(.NUM_CH(NCH)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .stall     (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [31:0] val;
   } sb_t;

   typedef struct {
      int          ch;
      logic [31:0] din;
      logic [31:0] dout;
   } vec_t;

   sb_t            sb [$];
   int             checks = 0;
   int             passes = 0;
   int             acc_cnt [NCH];
   int             out_cnt [NCH];
   logic [NCH-1:0] last_acc;
   logic [NCH-1:0] stall_or;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   task automatic drop_ch(input int c);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].ch == c) sb.delete(i);
      end
   endtask

   task automatic pop_check(input int c);
      int idx;
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].ch == c && idx < 0) idx = i;
      end
      if (idx < 0) begin
         checks++;
         $display("FAIL sb_ch%0d_unexpected: got out_valid=1 data=0x%08h, required no output",
                  c, out_data[c*32 +: 32]);
      end else begin
         check($sformatf("sb_ch%0d_data", c), out_data[c*32 +: 32], sb[idx].val);
         sb.delete(idx);
      end
   endtask

   // Inputs are set at the negedge; acceptance is decided just before the
   // rising edge, outputs are compared at the following negedge.
   task automatic tick();
      sb_t e;
      #1;
      stall_or = stall_or | stall;
      for (int c = 0; c < NCH; c++) begin
         if (flush[c]) drop_ch(c);
         last_acc[c] = in_valid[c] & ~stall[c] & ~flush[c];
         if (last_acc[c]) begin
            e.ch  = c;
            e.val = in_data[c*32 +: 32] + TOTAL_ADD;
            sb.push_back(e);
            acc_cnt[c]++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         if (out_valid[c]) begin
            out_cnt[c]++;
            pop_check(c);
         end
      end
   endtask

   task automatic do_reset();
      in_valid = '0;
      flush    = '0;
      in_data  = '0;
      rst_n    = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         acc_cnt[c] = 0;
         out_cnt[c] = 0;
      end
      stall_or = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   initial begin
      vec_t        vt [6];
      int          lat;
      int          t0a, t0b, t1;
      logic [31:0] d0a, d0b, d1;
      int          tot;

      vt[0] = '{0, 32'h0000_0010, 32'h0000_0112};
      vt[1] = '{0, 32'hFFFF_FEFF, 32'h0000_0001};
      vt[2] = '{1, 32'h0000_0000, 32'h0000_0102};
      vt[3] = '{1, 32'hFFFF_FFFF, 32'h0000_0101};
      vt[4] = '{0, 32'h1234_5678, 32'h1234_577A};
      vt[5] = '{1, 32'hFFFF_FEFE, 32'h0000_0000};

      rst_n    = 1'b0;
      in_valid = '0;
      flush    = '0;
      in_data  = '0;
      stall_or = '0;
      last_acc = '0;
      for (int c = 0; c < NCH; c++) begin
         acc_cnt[c] = 0;
         out_cnt[c] = 0;
      end
      #3;
      check("reset_out_valid", 32'(out_valid), 32'h0);
      check("reset_out_data", 32'(|out_data), 32'h0);
      check("reset_stall", 32'(stall), 32'h0);
      do_reset();

      // single items, one at a time
      for (int i = 0; i < 6; i++) begin
         in_data = '0;
         in_data[vt[i].ch*32 +: 32] = vt[i].din;
         in_valid = '0;
         in_valid[vt[i].ch] = 1'b1;
         stall_or = '0;
         tick();
         in_valid = '0;
         lat = 1;
         while (!out_valid[vt[i].ch] && lat < 12) begin
            tick();
            lat++;
         end
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
         check($sformatf("vec%0d_data", i), out_data[vt[i].ch*32 +: 32], vt[i].dout);
         tick();
         check($sformatf("vec%0d_pulse_end", i), 32'(out_valid[vt[i].ch]), 32'h0);
         check($sformatf("vec%0d_no_stall", i), 32'(stall_or), 32'h0);
      end

      // contention right after reset, then a collision with pointer at ch1
      do_reset();
      in_data = '0;
      in_data[0 +: 32]  = 32'h1;
      in_data[32 +: 32] = 32'h2;
      in_valid = '0;
      in_valid[0] = 1'b1;
      in_valid[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      in_data[0 +: 32] = 32'h5;
      tick();
      in_valid = '0;
      #1;
      check("cont_stall0", 32'(stall[0]), 32'h0);
      check("cont_stall1", 32'(stall[1]), 32'h1);
`ifdef PIPE_GLOBAL_STALL_EN
      check("cont_stall2_global", 32'(stall[2]), 32'h1);
`endif
      tick();
      #1;
      check("favour_stall0", 32'(stall[0]), 32'h1);
      check("favour_stall1", 32'(stall[1]), 32'h0);
      t0a = 0; t0b = 0; t1 = 0;
      d0a = '0; d0b = '0; d1 = '0;
      for (int e = 4; e <= 10; e++) begin
         tick();
         if (out_valid[0]) begin
            if (t0a == 0) begin t0a = e; d0a = out_data[0 +: 32]; end
            else if (t0b == 0) begin t0b = e; d0b = out_data[0 +: 32]; end
         end
         if (out_valid[1] && t1 == 0) begin t1 = e; d1 = out_data[32 +: 32]; end
      end
      check("cont_ch0_edge", 32'(t0a), 32'd4);
      check("cont_ch0_data", d0a, 32'h103);
      check("cont_ch1_edge", 32'(t1), 32'd5);
      check("cont_ch1_data", d1, 32'h104);
      check("cont_ch0b_edge", 32'(t0b), 32'd6);
      check("cont_ch0b_data", d0b, 32'h107);

      // continuous streams on ch0 and ch1
      do_reset();
      in_data = '0;
      in_data[0 +: 32]  = 32'h1000;
      in_data[32 +: 32] = 32'h2000;
      in_valid = '0;
      in_valid[0] = 1'b1;
      in_valid[1] = 1'b1;
      for (int k = 0; k < 24; k++) begin
         tick();
         if (last_acc[0]) in_data[0 +: 32]  = in_data[0 +: 32] + 32'h1;
         if (last_acc[1]) in_data[32 +: 32] = in_data[32 +: 32] + 32'h1;
      end
      in_valid = '0;
      repeat (12) tick();
      tot = acc_cnt[0] + acc_cnt[1];
      check("stream_acc_total", 32'(tot), 32'd26);
      check("stream_acc_ch0", 32'(acc_cnt[0]), 32'd13);
      check("stream_acc_ch1", 32'(acc_cnt[1]), 32'd13);
      check("stream_out_ch0", 32'(out_cnt[0]), 32'd13);
      check("stream_out_ch1", 32'(out_cnt[1]), 32'd13);
      check("stream_sb_empty", 32'(sb.size()), 32'd0);

      // flush ch1 with three items in flight while ch0 requests
      do_reset();
      in_data = '0;
      in_valid = '0;
      in_data[32 +: 32] = 32'h20; in_valid[1] = 1'b1;
      tick();
      in_data[32 +: 32] = 32'h21;
      in_data[0 +: 32]  = 32'h30; in_valid[0] = 1'b1;
      tick();
      in_data[32 +: 32] = 32'h22; in_valid[0] = 1'b0;
      tick();
      in_data[32 +: 32] = 32'h23;
      flush[1] = 1'b1;
      #1;
      check("flush_stall0", 32'(stall[0]), 32'h0);
      check("flush_stall1", 32'(stall[1]), 32'h0);
      tick();
      flush = '0;
      in_valid = '0;
      repeat (10) tick();
      check("flush_ch1_no_out", 32'(out_cnt[1]), 32'd0);
      check("flush_ch0_out", 32'(out_cnt[0]), 32'd1);
      in_data[32 +: 32] = 32'h40;
      in_valid[1] = 1'b1;
      tick();
      in_valid = '0;
      repeat (6) tick();
      check("flush_ch1_new_out", 32'(out_cnt[1]), 32'd1);
      check("flush_sb_empty", 32'(sb.size()), 32'd0);

      // reset asserted mid-stream
      do_reset();
      in_data = '0;
      in_valid = '0;
      in_valid[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data[0 +: 32] = 32'h50 + 32'(k);
         tick();
      end
      in_valid = '0;
      tick();
      check("rst_pre_out_valid", 32'(out_valid[0]), 32'h1);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("rst_async_out_valid", 32'(out_valid), 32'h0);
      check("rst_async_out_data", 32'(|out_data), 32'h0);
      check("rst_async_stall", 32'(stall), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < NCH; c++) out_cnt[c] = 0;
      repeat (8) tick();
      check("rst_no_out_after", 32'(out_cnt[0] + out_cnt[1]), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
